pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch flushes and data-memory wait states. It also keeps saturating stall/flush performance counters and a memory-wait watchdog that halts the pipeline.

## Interface
- MEM_TIMEOUT, 64: consecutive memory-busy cycles that trigger a halt (must be 2 or more).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  source register Rs of the instruction in ID.
- id_rt  in  5  source register Rt of the instruction in ID.
- ex_mem_read  in  1  instruction in EX is a load (ID/EX register output).
- ex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  taken branch resolved in the MEM stage (EX/MEM register output).
- mem_req  in  1  data memory access active this cycle.
- mem_ready  in  1  data memory completes this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  synchronous clear to bubble (applies when the matching enable is 1).
- halted  out  1  watchdog halt, sticky until reset.
- stall_cnt  out  CNT_W  cycles with pc_en=0 (excluding halt).
- flush_cnt  out  CNT_W  branch flush events.

## Operation
- State register: RUN, WAIT, HALT. Reset state is RUN.
- Combinational conditions:
  - mem_busy = mem_req & ~mem_ready.
  - load_use = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Outputs are combinational from state and inputs. Priority, highest first:
  - HALT state: all enables 0, all flushes 0.
  - mem_busy: freeze. All enables 0, all flushes 0.
  - branch_taken: all enables 1; if_id_flush, id_ex_flush and ex_mem_flush all 1.
  - load_use: pc_en=0, if_id_en=0, id_ex_flush=1, all other enables 1.
  - Otherwise: all enables 1, all flushes 0.
- Simultaneous mem_busy and branch_taken: freeze wins. branch_taken is held by the frozen EX/MEM register, so the flush occurs in the first non-busy cycle.
- Simultaneous branch_taken and load_use: the flush wins and no bubble is inserted, because the instruction in ID is squashed.
- Transitions:
  - RUN→WAIT when mem_busy.
  - WAIT→RUN when ~mem_busy.
  - RUN/WAIT→HALT when mem_busy and wait_cnt == MEM_TIMEOUT-1.
  - HALT is left only through reset.
- wait_cnt (internal, width $clog2(MEM_TIMEOUT)):
  - Increments on each mem_busy cycle outside HALT.
  - Clears to 0 on any non-busy cycle.
- halted = (state == HALT).
- stall_cnt increments when pc_en==0 and state != HALT.
- flush_cnt increments when the branch flush row is selected.
- Both counters saturate at all-ones and never wrap.

## Timing
- Zero-latency control. Enables and flushes respond in the same cycle as the inputs; the pipeline registers sample them at the next rising clk.
- Load-use produces exactly one bubble. The next cycle the load is in MEM, so load_use deasserts.
- Branch flush lasts one cycle per taken branch. The flushed EX/MEM clears branch_taken on the next edge.
- Halt: after MEM_TIMEOUT consecutive busy cycles, halted=1 from the following cycle.
- Reset (rst_n low, asynchronous, including mid-stall or mid-wait):
  - State RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, halted=0.
  - All enables and flushes forced to 0 while rst_n is low.
- Reset release: normal priority logic applies from the first rising clk after rst_n goes high.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum (RUN, WAIT, HALT);
  - REG_ZERO = 5'd0;
  - REG_ADDR_W = 5.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output q), instantiated twice for stall_cnt and flush_cnt.
- Hazard detection and priority mux stay inline.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0→1; next cycle all enables 1.
- Zero register: ex_mem_read=1, ex_rt=0, id_rt=0 → no stall; stall_cnt stays 0.
- Branch flush: branch_taken=1 for one cycle → if_id_flush, id_ex_flush and ex_mem_flush all 1, pc_en=1; flush_cnt=1.
- Memory wait plus branch: mem_req=1, mem_ready=0 for 3 cycles with branch_taken=1 held → 3 freeze cycles (stall_cnt=3), then 1 flush cycle (flush_cnt=1), state back to RUN.
- Watchdog: MEM_TIMEOUT=4, mem_busy held → halted=1 on cycle 5; all enables 0 even after mem_ready=1; rst_n pulse low → halted=0 and counters 0.
- Saturation: CNT_W=4 with 20 consecutive load-use cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Pure declarations; no logic, no latency, no backpressure.
// Imported by pipe_hazard_ctrl.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after inc. Backpressure: none, inc ignored at saturation.
// Cleared asynchronously by rst_n.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, memory freeze, watchdog.
// Latency: enables/flushes are combinational (same cycle). Backpressure: mem_busy freezes every stage.
// Watchdog halt is sticky until rst_n.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    ctrl_state_e       state_q;
    ctrl_state_e       state_d;
    logic [WAIT_W-1:0] wait_cnt_q;

    logic mem_busy;
    logic load_use;
    logic wait_last;
    logic br_row;
    logic [4:0] en_int;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0] flush_int; // {if_id, id_ex, ex_mem}

    assign mem_busy  = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rt != REG_ZERO) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign wait_last = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        en_int    = 5'b00000;
        flush_int = 3'b000;
        br_row    = 1'b0;
        if (state_q == HALT) begin
            en_int = 5'b00000;
        end else if (mem_busy) begin
            en_int = 5'b00000;
        end else if (branch_taken) begin
            // Squashing ID also covers any simultaneous load-use, so no bubble is needed.
            br_row    = 1'b1;
            en_int    = 5'b11111;
            flush_int = 3'b111;
        end else if (load_use) begin
            en_int    = 5'b00111;
            flush_int = 3'b010;
        end else begin
            en_int = 5'b11111;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_busy) state_d = wait_last ? HALT : WAIT;
            end
            WAIT: begin
                if (mem_busy && wait_last) state_d = HALT;
                else if (!mem_busy)        state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!mem_busy) begin
                wait_cnt_q <= '0;
            end else if (state_q != HALT) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    // Controls are forced inactive for the whole time reset is asserted.
    assign pc_en        = en_int[4] & rst_n;
    assign if_id_en     = en_int[3] & rst_n;
    assign id_ex_en     = en_int[2] & rst_n;
    assign ex_mem_en    = en_int[1] & rst_n;
    assign mem_wb_en    = en_int[0] & rst_n;
    assign if_id_flush  = flush_int[2] & rst_n;
    assign id_ex_flush  = flush_int[1] & rst_n;
    assign ex_mem_flush = flush_int[0] & rst_n;
    assign halted       = (state_q == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~en_int[4] & (state_q != HALT)),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_row),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
// Small MEM_TIMEOUT and CNT_W so the watchdog and saturation are reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_mem_read, branch_taken, mem_req, mem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush;
    logic          halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_halt;
    int m_run;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl_vec();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush};
    endfunction

    task automatic model_clear();
        m_halt  = 1'b0;
        m_run   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Asynchronous reset asserted between clock edges, with inputs that would otherwise enable everything.
    task automatic do_reset();
        @(negedge clk);
        #2;
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", {24'd0, ctl_vec()}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
        chk("rst_flush", {28'd0, flush_cnt}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_ctl", {24'd0, ctl_vec()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One pipeline cycle: drive at negedge, check controls mid-cycle, check state after the edge.
    task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] ert, input logic br, input logic req, input logic rdy);
        logic [7:0] e;
        bit busy, lu;
        @(negedge clk);
        id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
        branch_taken = br; mem_req = req; mem_ready = rdy;
        busy = req && !rdy;
        lu   = mr && (ert != 5'd0) && (ert == rs || ert == rt);
        if (m_halt || busy) e = 8'b00000_000;
        else if (br)        e = 8'b11111_111;
        else if (lu)        e = 8'b00111_010;
        else                e = 8'b11111_000;
        #1;
        chk("ctl", {24'd0, ctl_vec()}, {24'd0, e});
        if (!m_halt) begin
            if (!e[7] && m_stall < CMAX) m_stall++;
            if (br && !busy && m_flush < CMAX) m_flush++;
            if (busy) begin
                m_run++;
                if (m_run == MT) m_halt = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        model_clear();
        #12;
        do_reset();

        // Load-use: one bubble, then free flow
        cycle(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        chk("lu_stall_one", {28'd0, stall_cnt}, 32'd1);
        cycle(5'd9, 5'd3, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);

        // Load into r0 never stalls
        cycle(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("r0_no_stall", {28'd0, stall_cnt}, 32'd1);

        // Branch flush, also wins against a simultaneous load-use
        cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("br_flush_one", {28'd0, flush_cnt}, 32'd1);
        cycle(5'd4, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);

        // Memory wait with branch held: 3 freezes then the flush
        do_reset();
        repeat (3) cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("wait_stall3", {28'd0, stall_cnt}, 32'd3);
        chk("wait_flush1", {28'd0, flush_cnt}, 32'd1);
        cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Watchdog: MT busy cycles halt, memory completion does not release it
        do_reset();
        repeat (MT) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("wd_halted", {31'd0, halted}, 32'd1);
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        do_reset();

        // Busy run one short of the timeout, broken, then again: no halt
        repeat (MT - 1) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (MT - 1) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("wd_no_halt", {31'd0, halted}, 32'd0);

        // Saturation
        do_reset();
        repeat (20) cycle(5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        chk("stall_sat", {28'd0, stall_cnt}, CMAX);

        // Randomized traffic with occasional asynchronous resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 300) == 0 || (m_halt && ($urandom % 8) == 0)) begin
                do_reset();
            end
            cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom % 2),
                  5'($urandom_range(0, 3)), 1'(($urandom % 4) == 0), 1'($urandom % 2),
                  1'(($urandom % 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
